// File: rtl/obstacle_pkg.sv
// Shared types, widths and helpers for the obstacle spawn scheduler.
// The LFSR step and reload arithmetic live here so the top and the LFSR agree on them.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OFFER = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int              TIMER_W     = 9;
  localparam int              TYPE_W      = 2;
  localparam logic [TIMER_W-1:0] BASE_RELOAD = 9'd508;
  // Feedback taps at bits 7, 5, 4, 3.
  localparam logic [7:0]      LFSR_TAPS   = 8'b1011_1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [TIMER_W-1:0] calc_reload(input logic [1:0] rnd,
                                                     input logic [1:0] lvl,
                                                     input int shift);
    logic [TIMER_W-1:0] offset;
    offset = TIMER_W'({7'd0, lvl} << shift);
    return BASE_RELOAD + TIMER_W'(rnd) - offset;
  endfunction

endpackage

// File: rtl/obstacle_lfsr.sv
// 8-bit Fibonacci LFSR; loads the seed on reset or load, shifts on advance.
module obstacle_lfsr
  import obstacle_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else if (load) begin
      lfsr_q <= seed;
    end else if (advance) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Paces obstacle spawns: a randomised down-timer per spawn, a valid/ready offer,
// and a difficulty level that shortens the timer every SPAWNS_PER_LEVEL spawns.
module obstacle_spawn_scheduler
  import obstacle_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED        = 8'hA5,
  parameter int         SPAWNS_PER_LEVEL = 8,
  parameter int         MAX_LEVEL        = 3,
  parameter int         LEVEL_SHIFT      = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               game_over,
  input  logic               tick,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [TYPE_W-1:0]  spawn_type,
  output logic [1:0]         level,
  output logic               running,
  output logic [TIMER_W-1:0] timer_count
);

  localparam int         CNT_W     = (SPAWNS_PER_LEVEL > 1) ? $clog2(SPAWNS_PER_LEVEL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWNS_PER_LEVEL - 1);
  localparam logic [1:0] LEVEL_MAX = 2'(MAX_LEVEL);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [1:0]          level_q, level_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic                lfsr_load, lfsr_adv;
  logic [7:0]          lfsr_val;
  logic [7:0]          lfsr_next;
  logic [1:0]          level_up;

  obstacle_lfsr u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (LFSR_SEED),
    .value   (lfsr_val)
  );

  assign lfsr_next = lfsr_step(lfsr_val);
  assign level_up  = (level_q == LEVEL_MAX) ? level_q : level_q + 2'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    type_d    = type_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          timer_d   = calc_reload(LFSR_SEED[1:0], 2'd0, LEVEL_SHIFT);
          level_d   = '0;
          cnt_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = HALT;
        end else if (tick) begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = OFFER;
            valid_d = 1'b1;
            type_d  = lfsr_val[3:2];
          end
        end
      end
      OFFER: begin
        // A collision wins over a same-cycle handshake: the spawn is dropped.
        if (game_over) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (spawn_ready) begin
          state_d  = RUN;
          valid_d  = 1'b0;
          lfsr_adv = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = level_up;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          timer_d = calc_reload(lfsr_next[1:0], level_d, LEVEL_SHIFT);
        end
      end
      HALT: begin
        if (start && !game_over) begin
          state_d   = RUN;
          timer_d   = calc_reload(LFSR_SEED[1:0], 2'd0, LEVEL_SHIFT);
          level_d   = '0;
          cnt_d     = '0;
          lfsr_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign spawn_valid = valid_q;
  assign spawn_type  = type_q;
  assign level       = level_q;
  assign timer_count = timer_q;
  assign running     = (state_q == RUN) || (state_q == OFFER);

endmodule
